snake_key_input: RTL and testbench
==================================

Name: snake_key_input

Overview:
Front-end input stage for the snake game. It conditions the raw active-low board push-buttons and feeds the game-process FSM a clean, single-cycle active-low `enter` strobe. It also maintains the snake's current heading (`dir`) for the movement logic. Sits between the board pins and the game-process FSM / snake movement engine.

Parameters:
DEBOUNCE_CYCLES, 500000, clk cycles a synchronised key level must stay unchanged to be accepted (10 ms at 50 MHz); legal range 2..2^CNT_W-1
CNT_W, 19, debounce counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_n  in  5  raw buttons, active-low, asynchronous: [0]=enter [1]=up [2]=down [3]=left [4]=right
start  in  1  high while the game FSM is in the game state
ready_sig  in  1  high while the game FSM is in the ready state
enter  out  1  active-low, exactly one-cycle pulse per accepted enter press; idle high
dir  out  2  current heading: 0=UP 1=DOWN 2=LEFT 3=RIGHT
dir_chg  out  1  one-cycle high pulse in the cycle `dir` takes a new value
key_stable_n  out  5  debounced key levels, active-low

Behaviour:
- Reset (asynchronous, rst_n low): sync flops = 1, stable levels = 1, counters = 0, enter = 1, dir = RIGHT(3), dir_chg = 0, key_stable_n = 5'b11111.
- Synchroniser: two-flop synchroniser per key; no logic ahead of it.
- Debounce, per key:
  - Counter clears whenever the synchronised level equals the stable level.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the stable level takes the synchronised level and the counter clears.
  - Any bounce back clears the counter; no partial credit.
- Press event: stable level goes 1->0. A release (0->1) produces no event.
- Latency: a clean raw edge held steady reaches the stable level DEBOUNCE_CYCLES+2 cycles later. The registered press event, which drives enter low or updates dir/dir_chg, follows one cycle after that: DEBOUNCE_CYCLES+3 cycles total.
- enter: low for exactly one cycle per press, regardless of hold duration. No auto-repeat. enter is independent of start/ready_sig.
- Direction register:
  - While ready_sig = 1, dir is forced to RIGHT every cycle. dir_chg pulses only if this force changes the value.
  - While start = 1, a direction press event loads dir unless it is the exact opposite of the current dir (UP<->DOWN, LEFT<->RIGHT). A rejected press produces no dir_chg.
  - A press of the current direction is accepted but yields no dir_chg.
  - Simultaneous direction events in the same cycle: priority up > down > left > right. Only the highest-priority event is considered; if it is a reversal, nothing changes and the lower-priority events are not evaluated.
  - When start = 0 and ready_sig = 0 (win/over states), dir holds and direction presses are discarded.
- Press events are never queued; an event that cannot be applied is dropped.
- Reset mid-debounce discards the partial count; a key already held low at reset release must complete a full debounce interval, then produces one press event.

Optional Feature:
SNAKE_DIR_TICK_LOCK_EN
- Defined:
  - Adds input move_tick (1 bit; one-cycle pulse per snake step).
  - At most one accepted direction change between consecutive move_tick pulses.
  - The reversal check compares against the heading latched at the last move_tick, not the live dir. This blocks two quick turns (e.g. UP then LEFT while heading RIGHT) from producing a reversal within one step.
  - The lock flag clears on move_tick, on ready_sig, and on reset.
  - A press in the same cycle as move_tick is evaluated against the pre-tick latched heading, and the lock it sets survives that tick.
- Undefined: no move_tick port; behaviour exactly as in Behaviour.

Decomposition:
- Shared package snake_pkg:
  - DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT (2-bit) encodings
  - KEY_ENTER..KEY_RIGHT index constants
  - DIR_RESET = DIR_RIGHT
- One sub-module snake_debounce (synchroniser + counter + stable level + press pulse, parameterised by DEBOUNCE_CYCLES/CNT_W), instantiated 5 times. Direction logic stays in the top.

Test Plan:
1. DEBOUNCE_CYCLES=8; key_n[0] low and held 40 cycles -> enter low exactly once, 11 cycles after the edge; key_stable_n[0]=0.
2. key_n[0] bounces 0/1 every 5 cycles for 30 cycles, then settles low -> no enter pulse during the bounce; one pulse 11 cycles after the final settle.
3. ready_sig=1 -> dir=3; then start=1, press up -> dir=0 with a dir_chg pulse; press down -> dir stays 0, no dir_chg; press left -> dir=2.
4. start=1, dir=RIGHT; up and left press events in the same cycle -> dir=UP (up wins); left is dropped.
5. Assert rst_n low mid-debounce (count 5 of 8) while key held -> all outputs return to reset values; after release, the pulse fires 11 cycles later.
6. With SNAKE_DIR_TICK_LOCK_EN, dir=RIGHT: up then left before move_tick -> dir=UP, left ignored; after move_tick, left accepted -> dir=LEFT.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game input stage: heading codes and key indices.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  localparam int KEY_ENTER = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_LEFT  = 3;
  localparam int KEY_RIGHT = 4;
  localparam int NUM_KEYS  = 5;

  // Opposite headings differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_debounce.sv
// One key: 2-flop synchroniser, hold-time debounce counter, stable level and
// a registered single-cycle press strobe on the accepted 1->0 transition.
module snake_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic stable_n,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      stable_n <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      // Any return to the stable level wipes the count: no partial credit.
      if (s2 == stable_n) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable_n <= s2;
        cnt      <= '0;
        press    <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_key_input.sv
// Key front end: debounces the five buttons, emits the active-low enter strobe
// and tracks the snake heading. Optional SNAKE_DIR_TICK_LOCK_EN adds move_tick.
module snake_key_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key_n,
  input  logic       start,
  input  logic       ready_sig,
`ifdef SNAKE_DIR_TICK_LOCK_EN
  input  logic       move_tick,
`endif
  output logic       enter,
  output logic [1:0] dir,
  output logic       dir_chg,
  output logic [4:0] key_stable_n
);

  logic [NUM_KEYS-1:0] press;
  dir_t                dir_q, cand, ref_dir;
  logic                ev_any, lock, ok_turn;

  snake_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db [NUM_KEYS-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_n),
    .stable_n(key_stable_n),
    .press   (press)
  );

  // Only the highest-priority direction event is ever considered.
  always_comb begin
    ev_any = |press[KEY_RIGHT:KEY_UP];
    cand   = DIR_RIGHT;
    if (press[KEY_UP])        cand = DIR_UP;
    else if (press[KEY_DOWN]) cand = DIR_DOWN;
    else if (press[KEY_LEFT]) cand = DIR_LEFT;
  end

  assign ok_turn = start && ev_any && !lock && (cand != dir_opposite(ref_dir));

`ifdef SNAKE_DIR_TICK_LOCK_EN
  dir_t head_q;
  logic lock_q;

  assign ref_dir = head_q;
  assign lock    = lock_q;

  // Reversal check uses the heading at the last step; one turn per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= DIR_RESET;
      lock_q <= 1'b0;
    end else if (ready_sig) begin
      head_q <= DIR_RESET;
      lock_q <= 1'b0;
    end else begin
      if (move_tick) begin
        head_q <= dir_q;
        lock_q <= 1'b0;
      end
      if (ok_turn && (cand != dir_q)) lock_q <= 1'b1;
    end
  end
`else
  assign ref_dir = dir_q;
  assign lock    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter   <= 1'b1;
      dir_q   <= DIR_RESET;
      dir_chg <= 1'b0;
    end else begin
      enter   <= ~press[KEY_ENTER];
      dir_chg <= 1'b0;
      if (ready_sig) begin
        dir_q   <= DIR_RESET;
        dir_chg <= (dir_q != DIR_RESET);
      end else if (ok_turn) begin
        dir_q   <= cand;
        dir_chg <= (cand != dir_q);
      end
    end
  end

  assign dir = dir_q;

endmodule

// File: tb/tb_snake_key_input.sv
// Directed bench: expected enter / dir_chg events are queued at stimulus time
// and compared against events captured from the DUT.
module tb_snake_key_input;

  localparam int DEB = 8;
  localparam int LAT = DEB + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] key_n;
  logic       start, ready_sig, move_tick;
  logic       enter, dir_chg;
  logic [1:0] dir;
  logic [4:0] key_stable_n;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int got_ent[$], exp_ent[$];
  int got_chg_c[$], got_chg_d[$], exp_chg_c[$], exp_chg_d[$];

  snake_key_input #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .start       (start),
    .ready_sig   (ready_sig),
`ifdef SNAKE_DIR_TICK_LOCK_EN
    .move_tick   (move_tick),
`endif
    .enter       (enter),
    .dir         (dir),
    .dir_chg     (dir_chg),
    .key_stable_n(key_stable_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (enter === 1'b0) got_ent.push_back(cyc);
    if (dir_chg === 1'b1) begin
      got_chg_c.push_back(cyc);
      got_chg_d.push_back(int'(dir));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain_enter(input string tag);
    check({tag, "_enter_count"}, got_ent.size(), exp_ent.size());
    while (got_ent.size() > 0 && exp_ent.size() > 0)
      check({tag, "_enter_cycle"}, got_ent.pop_front(), exp_ent.pop_front());
    got_ent.delete();
    exp_ent.delete();
  endtask

  task automatic drain_chg(input string tag);
    check({tag, "_chg_count"}, got_chg_c.size(), exp_chg_c.size());
    while (got_chg_c.size() > 0 && exp_chg_c.size() > 0) begin
      check({tag, "_chg_cycle"}, got_chg_c.pop_front(), exp_chg_c.pop_front());
      check({tag, "_chg_dir"}, got_chg_d.pop_front(), exp_chg_d.pop_front());
    end
    got_chg_c.delete(); got_chg_d.delete();
    exp_chg_c.delete(); exp_chg_d.delete();
  endtask

  // Hold one or more direction keys long enough for one press event.
  task automatic press(input logic [4:0] mask, input int exp_dir, input bit exp_change);
    key_n = ~mask;
    if (exp_change) begin
      exp_chg_c.push_back(cyc + LAT);
      exp_chg_d.push_back(exp_dir);
    end
    tick(14);
    key_n = 5'h1f;
    tick(14);
  endtask

  initial begin
    rst_n = 1'b0; key_n = 5'h1f; start = 1'b0; ready_sig = 1'b0; move_tick = 1'b0;
    tick(3);
    check("rst_enter", int'(enter), 1);
    check("rst_dir", int'(dir), 3);
    check("rst_dir_chg", int'(dir_chg), 0);
    check("rst_stable", int'(key_stable_n), 31);
    rst_n = 1'b1;
    tick(3);

    // 1: clean hold
    key_n[0] = 1'b0;
    exp_ent.push_back(cyc + LAT);
    tick(40);
    check("t1_stable0", int'(key_stable_n[0]), 0);
    key_n[0] = 1'b1;
    tick(15);
    check("t1_stable_rel", int'(key_stable_n[0]), 1);
    drain_enter("t1");

    // 2: bounce then settle
    for (int i = 0; i < 6; i++) begin
      key_n[0] = i[0];
      tick(5);
    end
    key_n[0] = 1'b0;
    exp_ent.push_back(cyc + LAT);
    tick(30);
    key_n[0] = 1'b1;
    tick(15);
    drain_enter("t2");

    // 3: ready force, then turns with reversal rejected
    ready_sig = 1'b1;
    tick(3);
    check("t3_ready_dir", int'(dir), 3);
    ready_sig = 1'b0; start = 1'b1;
    press(5'b00010, 0, 1'b1);
    check("t3_up", int'(dir), 0);
    press(5'b00100, 0, 1'b0);
    check("t3_down_rej", int'(dir), 0);
    press(5'b00010, 0, 1'b0);
    check("t3_same", int'(dir), 0);
    press(5'b01000, 2, 1'b1);
    check("t3_left", int'(dir), 2);
    ready_sig = 1'b1;
    exp_chg_c.push_back(cyc + 1);
    exp_chg_d.push_back(3);
    tick(3);
    ready_sig = 1'b0;
    check("t3_ready_back", int'(dir), 3);
    drain_chg("t3");

    // 4: simultaneous up + left, up wins
    press(5'b01010, 0, 1'b1);
    check("t4_dir", int'(dir), 0);
    drain_chg("t4");
    start = 1'b0;
    press(5'b10000, 0, 1'b0);
    check("t4_idle_hold", int'(dir), 0);
    drain_chg("t4_idle");

    // 5: reset mid-debounce while held
    key_n[0] = 1'b0;
    tick(7);
    rst_n = 1'b0;
    #1;
    check("t5_rst_enter", int'(enter), 1);
    check("t5_rst_dir", int'(dir), 3);
    check("t5_rst_chg", int'(dir_chg), 0);
    check("t5_rst_stable", int'(key_stable_n), 31);
    tick(2);
    rst_n = 1'b1;
    exp_ent.push_back(cyc + LAT);
    tick(20);
    key_n[0] = 1'b1;
    tick(15);
    drain_enter("t5");
    drain_chg("t5");

`ifdef SNAKE_DIR_TICK_LOCK_EN
    // 6: one turn per step
    start = 1'b1;
    press(5'b00010, 0, 1'b1);
    press(5'b01000, 0, 1'b0);
    check("t6_locked", int'(dir), 0);
    move_tick = 1'b1;
    tick(1);
    move_tick = 1'b0;
    press(5'b01000, 2, 1'b1);
    check("t6_left", int'(dir), 2);
    drain_chg("t6");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
